// File: rtl/shift_controller64.sv
// Loads a 64-bit word and shifts it left by a requested amount, one bit per
// cycle, with stall support, a serial output of the bits leaving bit 63 and a completion pulse.
module shift_controller64 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [63:0] Data,
  input  logic [5:0]  Amount,
  input  logic        Hold,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] Result,
  output logic        SerialOut,
  output logic        ShiftValid
);

  localparam int unsigned DataW = 64;
  localparam int unsigned CntW  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               serial_q, serial_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    valid_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          shreg_d = Data;
          cnt_d   = Amount;
          state_d = (Amount != CntW'(0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (!Hold) begin
          shreg_d  = {shreg_q[DataW-2:0], 1'b0};
          serial_d = shreg_q[DataW-1];
          valid_d  = 1'b1;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Reset dominates Start, Hold and any in-flight job
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Result     = shreg_q;
  assign SerialOut  = serial_q;
  assign ShiftValid = valid_q;

endmodule

// File: tb/tb_shift_controller64.sv
// Directed self-checking bench for shift_controller64.
module tb_shift_controller64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [63:0] Data = '0;
  logic [5:0]  Amount = '0;
  logic        Hold = 1'b0;
  logic        Busy, Done, SerialOut, ShiftValid;
  logic [63:0] Result;

  int vectors = 0;
  int miscompares = 0;

  shift_controller64 dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Data(Data), .Amount(Amount),
    .Hold(Hold), .Busy(Busy), .Done(Done), .Result(Result),
    .SerialOut(SerialOut), .ShiftValid(ShiftValid)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Runs one job: accept at edge 0, Hold high on edges [h_from, h_from+h_len),
  // Hold also high on the DONE->IDLE edge. Edge indices follow the accept edge.
  task automatic run_job(input logic [63:0] d, input logic [5:0] amt,
                         input int h_from, input int h_len,
                         output int done_edge, output int nvalid, output int nones,
                         output logic [63:0] res_done, output logic done_after,
                         output logic busy_after, output logic [63:0] res_after);
    int e;
    done_edge = -1; nvalid = 0; nones = 0; res_done = '0;
    Start = 1'b1; Data = d; Amount = amt; Hold = (h_from == 0 && h_len > 0);
    step();
    e = 0;
    Start = 1'b0; Data = ~d; Amount = ~amt;
    while (e < 200) begin
      if (ShiftValid) begin
        nvalid++;
        if (SerialOut) nones++;
      end
      if (Done) begin
        done_edge = e;
        res_done = Result;
        break;
      end
      Hold = (e + 1 >= h_from) && (e + 1 < h_from + h_len);
      step();
      e++;
    end
    Hold = 1'b1;
    step();
    Hold = 1'b0;
    done_after = Done; busy_after = Busy; res_after = Result;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Data = '1; Amount = 6'd5; Hold = 1'b1;
    step(); step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", Busy); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", Done); end
    vectors++; if (Result !== 64'h0) begin miscompares++; $display("FAIL rst_result: got %h want 0", Result); end
    vectors++; if (SerialOut !== 1'b0) begin miscompares++; $display("FAIL rst_serial: got %b want 0", SerialOut); end
    vectors++; if (ShiftValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", ShiftValid); end
    Reset = 1'b0; Start = 1'b1; Data = 64'h0000_0000_0000_00A5; Amount = 6'd0; Hold = 1'b0;
    step();
    Start = 1'b0;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL first_busy: got %b want 1", Busy); end
    vectors++; if (Done !== 1'b1) begin miscompares++; $display("FAIL first_done: got %b want 1", Done); end
    vectors++; if (Result !== 64'hA5) begin miscompares++; $display("FAIL first_result: got %h want a5", Result); end
    step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL first_idle_busy: got %b want 0", Busy); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL first_idle_done: got %b want 0", Done); end
  endtask

  task automatic test_job(input string name, input logic [63:0] d, input logic [5:0] amt,
                          input int h_from, input int h_len, input int exp_edge,
                          input int exp_valid, input int exp_ones, input logic [63:0] exp_res);
    int de, nv, no;
    logic [63:0] rd, ra;
    logic da, ba;
    run_job(d, amt, h_from, h_len, de, nv, no, rd, da, ba, ra);
    vectors++; if (de !== exp_edge) begin miscompares++; $display("FAIL %s done_edge: got %0d want %0d", name, de, exp_edge); end
    vectors++; if (nv !== exp_valid) begin miscompares++; $display("FAIL %s valid_pulses: got %0d want %0d", name, nv, exp_valid); end
    vectors++; if (no !== exp_ones) begin miscompares++; $display("FAIL %s serial_ones: got %0d want %0d", name, no, exp_ones); end
    vectors++; if (rd !== exp_res) begin miscompares++; $display("FAIL %s result: got %h want %h", name, rd, exp_res); end
    vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL %s done_width: got %b want 0", name, da); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL %s idle_busy: got %b want 0", name, ba); end
    vectors++; if (ra !== exp_res) begin miscompares++; $display("FAIL %s idle_result: got %h want %h", name, ra, exp_res); end
  endtask

  task automatic test_shift_jobs();
    test_job("amt1", 64'h8000_0000_0000_0001, 6'd1, 0, 0, 1, 1, 1, 64'h0000_0000_0000_0002);
    test_job("amt63", 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 0, 0, 63, 63, 63, 64'h8000_0000_0000_0000);
    test_job("amt0", 64'h1234_5678_9ABC_DEF0, 6'd0, 0, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0);
    test_job("amt8", 64'h0123_4567_89AB_CDEF, 6'd8, 0, 0, 8, 8, 1, 64'h2345_6789_ABCD_EF00);
  endtask

  task automatic test_hold();
    test_job("hold_mid", 64'hF0F0_0000_0000_000F, 6'd4, 2, 3, 7, 4, 4, 64'h0F00_0000_0000_00F0);
    test_job("hold_idle", 64'h0000_0000_0000_0003, 6'd2, 0, 1, 2, 2, 0, 64'h0000_0000_0000_000C);
  endtask

  task automatic test_start_ignored();
    Start = 1'b1; Data = 64'h0000_0000_0000_0011; Amount = 6'd3; Hold = 1'b0;
    step();
    Data = 64'hDEAD_BEEF_CAFE_F00D; Amount = 6'd5;
    step(); step(); step();
    vectors++; if (Done !== 1'b1) begin miscompares++; $display("FAIL ign_done: got %b want 1", Done); end
    vectors++; if (Result !== 64'h88) begin miscompares++; $display("FAIL ign_result: got %h want 88", Result); end
    step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL ign_busy_done_edge: got %b want 0", Busy); end
    vectors++; if (Result !== 64'h88) begin miscompares++; $display("FAIL ign_result_idle: got %h want 88", Result); end
    Start = 1'b0;
    step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL ign_busy_after: got %b want 0", Busy); end
    vectors++; if (Result !== 64'h88) begin miscompares++; $display("FAIL ign_result_after: got %h want 88", Result); end
  endtask

  task automatic test_reset_mid();
    Start = 1'b1; Data = 64'h0000_0000_FFFF_0000; Amount = 6'd10; Hold = 1'b0;
    step();
    Start = 1'b0;
    step();
    vectors++; if (ShiftValid !== 1'b1) begin miscompares++; $display("FAIL mid_shift1_valid: got %b want 1", ShiftValid); end
    Reset = 1'b1; Start = 1'b1; Data = 64'h7777_7777_7777_7777; Amount = 6'd0;
    step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
    vectors++; if (Result !== 64'h0) begin miscompares++; $display("FAIL mid_rst_result: got %h want 0", Result); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", Done); end
    vectors++; if (ShiftValid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", ShiftValid); end
    Reset = 1'b0; Start = 1'b1; Data = 64'h0000_0000_0000_0055; Amount = 6'd1;
    step();
    Start = 1'b0;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL mid_new_busy: got %b want 1", Busy); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL mid_new_nodone: got %b want 0", Done); end
    step();
    vectors++; if (Done !== 1'b1) begin miscompares++; $display("FAIL mid_new_done: got %b want 1", Done); end
    vectors++; if (Result !== 64'hAA) begin miscompares++; $display("FAIL mid_new_result: got %h want aa", Result); end
    step();
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL mid_new_done_clear: got %b want 0", Done); end
  endtask

  initial begin
    test_reset();
    test_shift_jobs();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
